io_port_arbiter: RTL and testbench
==================================

IO_PORT_ARBITER -- requirements
Module: io_port_arbiter

Interface
REQ-001 Parameter BASE_A, default 11'h7FF, 11-bit value that address bits [15:5] must equal for an I/O hit.
REQ-002 Parameter WAIT_STATES, default 2, range 0..15, extra cycles io_sel is held beyond the first access cycle.
REQ-003 MasterClock  in  1  single system clock; all state changes on its rising edge.
REQ-004 RESETL  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-006 cpu_addr  in  16  CPU address.
REQ-007 cpu_wr  in  1  1 = write, 0 = read (CPU).
REQ-008 cpu_wdata  in  8  CPU write data.
REQ-009 cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-010 dsp_req, dsp_addr[15:0], dsp_wr, dsp_wdata[7:0]  in  DSP requester, same meaning as CPU set.
REQ-011 dsp_ack  out  1  one-cycle completion pulse to DSP.
REQ-012 rdata  out  8  read data of last completed read, valid in ack cycle and held until next read completes.
REQ-013 miss  out  1  one-cycle pulse coincident with ack when the access did not decode.
REQ-014 io_sel  out  1  I/O bank select strobe.
REQ-015 io_wr  out  1  write qualifier, valid while io_sel high.
REQ-016 io_reg  out  5  register index (latched addr[4:0]).
REQ-017 io_wdata  out  8  latched write data.
REQ-018 io_rdata  in  8  I/O bank read data, sampled on the last io_sel cycle.

Function
REQ-019 Decode: hit when latched addr[15:5] == BASE_A on all 11 bits; any mismatching bit is a miss.
REQ-020 FSM states IDLE, ACCESS, ACK; encoding free.
REQ-021 IDLE: no req -> stay; one req -> grant it; both req -> grant the requester not granted last (round robin); latch addr, wr, wdata of granted requester on the grant edge.
REQ-022 IDLE -> ACCESS on grant with hit; IDLE -> ACK on grant with miss.
REQ-023 ACCESS: io_sel=1, io_wr=latched wr, io_reg/io_wdata from latch; 4-bit counter loads WAIT_STATES on entry, decrements each cycle; leave to ACK in the cycle counter==0, so io_sel is high exactly WAIT_STATES+1 cycles.
REQ-024 Read hit: rdata loaded from io_rdata on the final ACCESS cycle edge.
REQ-025 ACK: granted requester's ack=1 for exactly one cycle, miss=1 if the access missed; io_sel=0; next state IDLE.
REQ-026 Latency from req rising (IDLE, uncontended) to ack: hit = WAIT_STATES+3 cycles, miss = 2 cycles.
REQ-027 Requests are not preempted; a req dropped during ACCESS does not abort the access and ack is still issued.
REQ-028 A req still high in the cycle after ack is treated as a new request and rearbitrated in IDLE.
REQ-029 Only one ack may be high in any cycle; cpu_ack and dsp_ack never both 1.
REQ-030 Miss accesses never assert io_sel and leave rdata unchanged.
REQ-031 Last-granted pointer updates on each grant; after reset it points to DSP, so CPU wins the first tie.

Reset
REQ-032 RESETL low asynchronously forces IDLE, io_sel=0, io_wr=0, cpu_ack=0, dsp_ack=0, miss=0, rdata=0, io_reg=0, io_wdata=0, counter=0, pointer=DSP.
REQ-033 Reset asserted mid-ACCESS drops io_sel immediately; no ack is issued for the aborted access.
REQ-034 After RESETL rises, the first grant occurs on the first MasterClock edge with a req high.

Verification
REQ-035 CPU read addr 16'hFFE3, WAIT_STATES=2, io_rdata=8'h5A -> io_sel high 3 cycles, io_reg=5'h03, io_wr=0, cpu_ack at cycle 5, rdata=8'h5A, miss=0.
REQ-036 DSP write addr 16'hFFE7 data 8'hC3 -> io_wr=1, io_wdata=8'hC3, io_reg=5'h07 during io_sel, dsp_ack once, cpu_ack=0.
REQ-037 CPU and DSP both req continuously from reset -> grants alternate CPU, DSP, CPU, DSP; acks never coincide.
REQ-038 CPU addr 16'hFBE0 (bit 10 clear) -> no io_sel, cpu_ack and miss together 2 cycles after req, rdata unchanged.
REQ-039 RESETL pulsed low in second ACCESS cycle -> io_sel falls asynchronously, no ack, FSM in IDLE; held req then completes normally after reset.
REQ-040 WAIT_STATES=0 hit -> io_sel high exactly 1 cycle, ack 3 cycles after req.

Source files
------------

// File: rtl/io_port_arbiter.sv
// io_port_arbiter: round-robin arbiter between CPU and DSP for one I/O register bank.
module io_port_arbiter #(
  parameter logic [10:0] BASE_A = 11'h7FF,
  parameter int WAIT_STATES = 2
) (
  input  logic        MasterClock,
  input  logic        RESETL,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  input  logic        dsp_req,
  input  logic [15:0] dsp_addr,
  input  logic        dsp_wr,
  input  logic [7:0]  dsp_wdata,
  output logic        dsp_ack,
  output logic [7:0]  rdata,
  output logic        miss,
  output logic        io_sel,
  output logic        io_wr,
  output logic [4:0]  io_reg,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t state, state_nx;
  logic gnt_cpu, gnt_any, hit, last_dsp, wr_l, miss_l;
  logic [15:0] addr_g;
  logic [3:0] cnt;
  // last_dsp doubles as "who owns the current access" since it only moves on a grant
  assign gnt_any = cpu_req | dsp_req;
  assign gnt_cpu = cpu_req & (~dsp_req | last_dsp);
  assign addr_g  = gnt_cpu ? cpu_addr : dsp_addr;
  assign hit     = addr_g[15:5] == BASE_A;
  assign io_sel  = state == ACCESS;
  assign io_wr   = io_sel & wr_l;
  assign cpu_ack = (state == ACK) & ~last_dsp;
  assign dsp_ack = (state == ACK) & last_dsp;
  assign miss    = (state == ACK) & miss_l;
  always_comb begin
    state_nx = state == IDLE   ? (gnt_any ? (hit ? ACCESS : ACK) : IDLE) :
               state == ACCESS ? (cnt == 4'd0 ? ACK : ACCESS) : IDLE;
  end
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      last_dsp <= 1'b1;
      wr_l     <= 1'b0;
      miss_l   <= 1'b0;
      io_reg   <= '0;
      io_wdata <= '0;
      rdata    <= '0;
      cnt      <= '0;
    end else begin
      if (state == IDLE && gnt_any) begin
        last_dsp <= ~gnt_cpu;
        wr_l     <= gnt_cpu ? cpu_wr : dsp_wr;
        io_wdata <= gnt_cpu ? cpu_wdata : dsp_wdata;
        io_reg   <= addr_g[4:0];
        miss_l   <= ~hit;
        cnt      <= 4'(WAIT_STATES);
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ACCESS && cnt == 4'd0 && !wr_l) rdata <= io_rdata;
    end
  end
endmodule

// File: tb/tb_io_port_arbiter.sv
// tb_io_port_arbiter: randomized scoreboard bench; a transaction-level model predicts grant order,
// latency, io strobes and read data, and a negedge monitor compares them against the DUT.
module tb_io_port_arbiter;
  localparam logic [10:0] BASE = 11'h7FF;
  localparam int W = 2;
  logic MasterClock = 0, RESETL = 0;
  logic cpu_req = 0, cpu_wr = 0, dsp_req = 0, dsp_wr = 0;
  logic [15:0] cpu_addr = 0, dsp_addr = 0;
  logic [7:0] cpu_wdata = 0, dsp_wdata = 0, io_rdata = 0;
  logic cpu_ack, dsp_ack, miss, io_sel, io_wr;
  logic [7:0] rdata, io_wdata;
  logic [4:0] io_reg;
  logic req0 = 0;
  logic [7:0] io_rdata0 = 0;
  logic ack0, dack0, miss0, sel0, wr0;
  logic [7:0] rdata0, wdata0;
  logic [4:0] reg0;
  int checks = 0, errors = 0, cyc = 0, sel_n = 0;
  typedef struct {
    bit dsp; bit miss; bit wr; logic [4:0] rg; logic [7:0] wd; logic [7:0] rd; int ack_cyc;
  } exp_t;
  exp_t sb[$];
  bit last_dsp = 1;
  logic [7:0] m_rdata = 0;

  io_port_arbiter #(.BASE_A(BASE), .WAIT_STATES(W)) u_dut (
    .MasterClock(MasterClock), .RESETL(RESETL),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_wr(dsp_wr), .dsp_wdata(dsp_wdata), .dsp_ack(dsp_ack),
    .rdata(rdata), .miss(miss), .io_sel(io_sel), .io_wr(io_wr), .io_reg(io_reg),
    .io_wdata(io_wdata), .io_rdata(io_rdata));

  io_port_arbiter #(.BASE_A(BASE), .WAIT_STATES(0)) u_w0 (
    .MasterClock(MasterClock), .RESETL(RESETL),
    .cpu_req(req0), .cpu_addr(16'hFFE1), .cpu_wr(1'b0), .cpu_wdata(8'h00), .cpu_ack(ack0),
    .dsp_req(1'b0), .dsp_addr(16'h0000), .dsp_wr(1'b0), .dsp_wdata(8'h00), .dsp_ack(dack0),
    .rdata(rdata0), .miss(miss0), .io_sel(sel0), .io_wr(wr0), .io_reg(reg0),
    .io_wdata(wdata0), .io_rdata(io_rdata0));

  always #5 MasterClock = ~MasterClock;
  always @(posedge MasterClock) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge RESETL) sel_n = 0;

  always @(negedge MasterClock) begin
    exp_t e;
    if (RESETL) begin
      chk("dual_ack", {31'd0, cpu_ack & dsp_ack}, 0);
      chk("miss_without_ack", {31'd0, miss & ~(cpu_ack | dsp_ack)}, 0);
      if (io_sel) begin
        sel_n++;
        chk("sel_has_txn", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          chk("io_wr", {31'd0, io_wr}, {31'd0, sb[0].wr});
          chk("io_reg", {27'd0, io_reg}, {27'd0, sb[0].rg});
          chk("io_wdata", {24'd0, io_wdata}, {24'd0, sb[0].wd});
        end
      end
      if (cpu_ack || dsp_ack) begin
        chk("ack_has_txn", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ack_who_dsp", {31'd0, dsp_ack}, {31'd0, e.dsp});
          chk("miss", {31'd0, miss}, {31'd0, e.miss});
          chk("sel_cycles", sel_n, e.miss ? 0 : W + 1);
          chk("ack_cycle", cyc, e.ack_cyc);
          chk("rdata", {24'd0, rdata}, {24'd0, e.rd});
        end
        sel_n = 0;
      end
    end
  end

  function automatic logic [15:0] rand_addr();
    logic [10:0] hi = BASE;
    int b = $urandom_range(0, 10);
    if ($urandom_range(0, 2) == 0) hi[b] = ~hi[b];
    return {hi, 5'($urandom)};
  endfunction

  task automatic wait_acks(logic [7:0] rd1);
    for (int n = 0; n < 100 && (cpu_req || dsp_req); n++) begin
      @(negedge MasterClock);
      if (cpu_ack || dsp_ack) io_rdata = rd1;
      if (cpu_ack) cpu_req = 0;
      if (dsp_ack) dsp_req = 0;
    end
    chk("req_done_in_time", {31'd0, cpu_req | dsp_req}, 0);
    cpu_req = 0;
    dsp_req = 0;
  endtask

  task automatic round(bit c_en, bit d_en, logic [15:0] ca, logic [15:0] da, bit cw, bit dw,
                       logic [7:0] cwd, logic [7:0] dwd, logic [7:0] rd0, logic [7:0] rd1);
    exp_t e;
    bit first_dsp;
    int t;
    @(negedge MasterClock);
    first_dsp = d_en && (!c_en || !last_dsp);
    t = cyc + 1;
    for (int i = 0; i < int'(c_en) + int'(d_en); i++) begin
      bit dsp = (i == 0) ? first_dsp : !first_dsp;
      logic [15:0] a = dsp ? da : ca;
      bit w = dsp ? dw : cw;
      bit h = a[15:5] == BASE;
      if (h && !w) m_rdata = (i == 0) ? rd0 : rd1;
      e.dsp = dsp; e.miss = !h; e.wr = w; e.rg = a[4:0]; e.wd = dsp ? dwd : cwd; e.rd = m_rdata;
      e.ack_cyc = t + (h ? W + 1 : 0);
      t = e.ack_cyc + 2;
      last_dsp = dsp;
      sb.push_back(e);
    end
    cpu_addr = ca; cpu_wr = cw; cpu_wdata = cwd;
    dsp_addr = da; dsp_wr = dw; dsp_wdata = dwd;
    io_rdata = rd0;
    cpu_req = c_en;
    dsp_req = d_en;
    wait_acks(rd1);
    repeat ($urandom_range(0, 2)) @(negedge MasterClock);
  endtask

  initial begin
    exp_t e;
    int k, n0, s0;
    #12;
    chk("rst_io_sel", {31'd0, io_sel}, 0);
    chk("rst_io_wr", {31'd0, io_wr}, 0);
    chk("rst_acks", {30'd0, cpu_ack, dsp_ack}, 0);
    chk("rst_miss", {31'd0, miss}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    chk("rst_io_reg", {27'd0, io_reg}, 0);
    chk("rst_io_wdata", {24'd0, io_wdata}, 0);
    @(negedge MasterClock);
    RESETL = 1;
    round(1, 0, 16'hFFE3, 16'h0, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h5A);
    round(0, 1, 16'h0, 16'hFFE7, 0, 1, 8'h00, 8'hC3, 8'h11, 8'h11);
    round(1, 0, 16'hFBE0, 16'h0, 0, 0, 8'h00, 8'h00, 8'hEE, 8'hEE);
    repeat (4) round(1, 1, {BASE, 5'($urandom)}, {BASE, 5'($urandom)}, 1'($urandom), 1'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    repeat (60) begin
      int s = $urandom_range(1, 3);
      round(s[0], s[1], rand_addr(), rand_addr(), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    // reset in the second ACCESS cycle, CPU keeps requesting through it
    @(negedge MasterClock);
    cpu_addr = {BASE, 5'h0A}; cpu_wr = 0; cpu_wdata = 8'h99; io_rdata = 8'h3C;
    e.dsp = 0; e.miss = 0; e.wr = 0; e.rg = 5'h0A; e.wd = 8'h99; e.rd = 8'h3C; e.ack_cyc = 0;
    sb.push_back(e);
    cpu_req = 1;
    repeat (2) @(negedge MasterClock);
    chk("pre_rst_io_sel", {31'd0, io_sel}, 1);
    #1 RESETL = 0;
    #1;
    chk("async_io_sel", {31'd0, io_sel}, 0);
    chk("async_acks", {30'd0, cpu_ack, dsp_ack}, 0);
    chk("async_rdata", {24'd0, rdata}, 0);
    chk("async_io_reg", {27'd0, io_reg}, 0);
    #1 RESETL = 1;
    last_dsp = 0;
    m_rdata = 8'h3C;
    sb[0].ack_cyc = cyc + 1 + W + 1;
    wait_acks(8'h3C);
    round(1, 1, {BASE, 5'h01}, {BASE, 5'h02}, 0, 0, 8'h00, 8'h00, 8'hA1, 8'hB2);
    // zero wait states on the second instance
    @(negedge MasterClock);
    k = cyc; n0 = 0; s0 = 0;
    io_rdata0 = 8'h77;
    req0 = 1;
    while (!ack0 && n0 < 20) begin
      @(negedge MasterClock);
      n0++;
      if (sel0) s0++;
    end
    req0 = 0;
    chk("w0_ack_cycle", cyc, k + 2);
    chk("w0_sel_cycles", s0, 1);
    chk("w0_rdata", {24'd0, rdata0}, 8'h77);
    chk("w0_miss", {31'd0, miss0}, 0);
    repeat (4) @(negedge MasterClock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
